// File: rtl/pcs_tx_idle_gen_if.sv
// pcs_tx_idle_gen_if: XGMII-in / MGT-out bundle for the idle generator
interface pcs_tx_idle_gen_if;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic [63:0] mgt_txdata;
  logic [7:0]  mgt_txcharisk;
  modport master(output xgmii_txd, xgmii_txc, input mgt_txdata, mgt_txcharisk);
  modport slave(input xgmii_txd, xgmii_txc, output mgt_txdata, mgt_txcharisk);
endinterface

// File: rtl/pcs_tx_idle_gen.sv
// pcs_tx_idle_gen: XGMII idle/control to 8b/10b code-group mapping with ||A||/||K||/||R|| randomisation
module pcs_tx_idle_gen #(
  parameter logic [6:0] PRBS_SEED = 7'h7F
) (
  input logic clk,
  input logic reset,
  pcs_tx_idle_gen_if.slave bus
);
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [4:0]  a;
    logic        t;
  } col_t;

  function automatic logic [6:0] lfsr(input logic [6:0] p);
    return {p[5:0], p[6] ^ p[5]};
  endfunction

  // One column: code-group mapping plus the per-column a_cnt/prev_t update
  function automatic col_t col_gen(input logic [31:0] d, input logic [3:0] c,
                                   input logic [6:0] p, input logic [4:0] a, input logic t);
    col_t r;
    logic idle, a_emit;
    idle = &c && d == {4{8'h07}};
    a_emit = idle && a == 5'd0;
    r.t = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r.t = r.t | (c[i] && d[8*i+:8] == 8'hFD);
      r.k[i] = c[i];
      r.d[8*i+:8] = idle ? (a_emit ? 8'h7C : (t || p[0]) ? 8'hBC : 8'h1C) :
                    !c[i] ? d[8*i+:8] :
                    d[8*i+:8] == 8'h07 ? 8'hBC :
                    d[8*i+:8] inside {8'hFB, 8'hFD, 8'h9C, 8'hFE} ? d[8*i+:8] : 8'hFE;
    end
    r.a = a_emit ? {1'b1, p[3:0]} : a - 5'(a != 5'd0);
    return r;
  endfunction

  logic [6:0]  prbs;
  logic [4:0]  a_cnt;
  logic        prev_t;
  logic [31:0] d0, d1;
  logic [3:0]  c0, c1;
  col_t        r0, r1;

  genvar n;
  for (n = 0; n < 4; n++) begin : g_lane
    assign d0[8*n+:8] = bus.xgmii_txd[16*n+:8];
    assign d1[8*n+:8] = bus.xgmii_txd[16*n+8+:8];
    assign c0[n] = bus.xgmii_txc[2*n];
    assign c1[n] = bus.xgmii_txc[2*n+1];
  end

  always_comb begin
    r0 = col_gen(d0, c0, prbs, a_cnt, prev_t);
    r1 = col_gen(d1, c1, lfsr(prbs), r0.a, r0.t);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mgt_txdata <= {8{8'hBC}};
      bus.mgt_txcharisk <= 8'hFF;
      prbs <= PRBS_SEED;
      a_cnt <= 5'd0;
      prev_t <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        bus.mgt_txdata[16*i+:8] <= r0.d[8*i+:8];
        bus.mgt_txdata[16*i+8+:8] <= r1.d[8*i+:8];
        bus.mgt_txcharisk[2*i] <= r0.k[i];
        bus.mgt_txcharisk[2*i+1] <= r1.k[i];
      end
      prbs <= lfsr(lfsr(prbs));
      a_cnt <= r1.a;
      prev_t <= r1.t;
    end
  end
endmodule

// File: doc/pcs_tx_idle_gen.md
PCS_TX_IDLE_GEN -- requirements
Module: pcs_tx_idle_gen

Interface
REQ-001 SHALL have parameter PRBS_SEED, default 7'h7F, the idle-randomiser LFSR value loaded at reset (nonzero).
REQ-002 SHALL have port clk  input  1  rising-edge clock; all logic synchronous to it.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port xgmii_txd  input  64  two XGMII columns; lane n col0 at [16n+7:16n], lane n col1 at [16n+15:16n+8].
REQ-005 SHALL have port xgmii_txc  input  8  control flags; lane n col0 at bit 2n, col1 at bit 2n+1.
REQ-006 SHALL have port mgt_txdata  output  64  8b/10b code-group data to the MGT, same lane/column layout as xgmii_txd.
REQ-007 SHALL have port mgt_txcharisk  output  8  K-flag per byte, same layout as xgmii_txc.

Function
REQ-008 SHALL process col0 before col1 each clock; all per-column state below advances once per column (twice per clk).
REQ-009 SHALL register outputs; latency exactly 1 clk from input to output.
REQ-010 SHALL classify a column as idle when all 4 lanes have control=1 and data=0x07.
REQ-011 SHALL map an idle column to one of ||A|| (4x 0x7C, K28.3), ||K|| (4x 0xBC, K28.5), ||R|| (4x 0x1C, K28.0), all with charisk=1.
REQ-012 SHALL select for an idle column with priority: a_cnt==0 -> ||A||; else previous column contained /T/ (control 0xFD) -> ||K||; else prbs[0]==1 -> ||K||; else ||R||.
REQ-013 SHALL, in non-idle columns, replace each control lane with data 0x07 by 0xBC (K28.5), charisk=1.
REQ-014 SHALL pass control bytes 0xFB (S), 0xFD (T), 0x9C (Q), 0xFE (E) unchanged with charisk=1.
REQ-015 SHALL map any other control byte to 0xFE (K30.7, error), charisk=1.
REQ-016 SHALL pass data lanes (control=0) unchanged with charisk=0.
REQ-017 SHALL keep a 5-bit a_cnt: per column, if ||A|| emitted load 16+prbs[3:0] (range 16..31, prbs value of that column); else decrement, saturating at 0.
REQ-018 SHALL hold a_cnt==0 (||A|| pending) through non-idle columns; ||A|| emitted at the first subsequent idle column.
REQ-019 SHALL keep a 7-bit LFSR prbs, polynomial x^7+x^6+1: next = {prbs[5:0], prbs[6]^prbs[5]}, advanced every column regardless of content.
REQ-020 SHALL keep a 1-bit prev_t flag: set when a column contains any lane with control=1 and data 0xFD; cleared otherwise; col1 uses col0 flag of same clk, col0 uses col1 flag of previous clk.
REQ-021 SHALL never emit ||A|| in two consecutive columns (guaranteed by REQ-017 reload >= 16).

Reset
REQ-022 SHALL, while reset high, drive mgt_txdata = {8{0xBC}}, mgt_txcharisk = 8'hFF.
REQ-023 SHALL on reset set prbs = PRBS_SEED, a_cnt = 0, prev_t = 0.
REQ-024 SHALL, on reset asserted mid-stream, discard in-flight column; first output after deassert reflects the first sampled input.

Verification
REQ-025 SHALL verify: reset, then continuous idle (txd all 0x07, txc 8'hFF) -> first output col0 = ||A|| (0x7C x4); next ||A|| exactly 17..32 columns later; gaps always 17..32.
REQ-026 SHALL verify: idle stream, PRBS_SEED=7'h7F -> K/R sequence matches a reference LFSR model column-for-column; all charisk=1.
REQ-027 SHALL verify: frame S (0xFB lane0) + data, ending with col0 = {0xFD,0x07,0x07,0x07} ctrl 4'hF -> output {0xFD,0xBC,0xBC,0xBC}; following idle col1 = ||K|| unless a_cnt==0 (then ||A||).
REQ-028 SHALL verify: a_cnt expires during a 100-column data frame -> no ||A|| inside frame; ||A|| on first idle column after frame.
REQ-029 SHALL verify: control byte 0x55 with txc=1 -> output 0xFE, charisk=1; data byte 0x07 with txc=0 -> output 0x07, charisk=0.
REQ-030 SHALL verify: reset pulsed for 1 clk mid-frame -> outputs {8{0xBC}}/8'hFF during reset; a_cnt=0 afterwards so next idle column is ||A||.
